// File: rtl/dk_stat_update.sv
// -----------------------------------------------------------------------------
// dk_stat_update
//
// Player statistics engine: keeps the banana count (smallD) and the lives
// count (bigD) for the stat register and tracks the player condition with
// a three-state FSM (ALIVE, INVULN, DEAD).
//
//   Clk        in   system clock, all state changes on its rising edge
//   Reset      in   synchronous active-high reset
//   frame_tick in   one-cycle pulse per video frame
//   hit        in   player overlaps an enemy (level, sampled on frame_tick)
//   collect    in   one-cycle pulse per banana picked up
//   restart    in   one-cycle pulse that leaves game-over
//   smallD     out  banana count, 0 .. COINS_PER_LIFE-1
//   bigD       out  lives count, 0 .. MAX_BIG
//   upd        out  one-cycle pulse whenever smallD or bigD changes
//   invuln     out  high while in INVULN
//   game_over  out  high while in DEAD
//
// All outputs are registered; they reflect the inputs sampled on the
// previous rising edge of Clk.
// -----------------------------------------------------------------------------
module dk_stat_update #(
    parameter logic [15:0] START_BIG      = 16'd10,
    parameter logic [15:0] MAX_BIG        = 16'd99,
    parameter logic [15:0] COINS_PER_LIFE = 16'd100,
    parameter logic [15:0] INVULN_FRAMES  = 16'd60
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic        collect,
    input  logic        restart,
    output logic [15:0] smallD,
    output logic [15:0] bigD,
    output logic        upd,
    output logic        invuln,
    output logic        game_over
);

    localparam logic [1:0] ST_ALIVE  = 2'd0;
    localparam logic [1:0] ST_INVULN = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] small_q, small_d;
    logic [15:0] big_q, big_d;
    logic [15:0] cnt_q, cnt_d;
    logic        upd_q, upd_d;
    logic        invuln_q, invuln_d;
    logic        game_over_q, game_over_d;

    logic [15:0] small_inc_s;
    logic [15:0] big_up_s;

    // Next-state computation for the FSM, counters and output registers.
    always_comb begin
        state_d     = state_q;
        small_d     = small_q;
        big_d       = big_q;
        cnt_d       = cnt_q;
        small_inc_s = small_q + 16'd1;
        big_up_s    = big_q;

        case (state_q)
            ST_ALIVE, ST_INVULN: begin
                // Banana pickup; a 1-up saturates at MAX_BIG before any hit
                // in the same cycle is subtracted.
                if (collect) begin
                    if (small_inc_s >= COINS_PER_LIFE) begin
                        small_d = 16'd0;
                        if (big_q < MAX_BIG) begin
                            big_up_s = big_q + 16'd1;
                        end else begin
                            big_up_s = MAX_BIG;
                        end
                    end else begin
                        small_d = small_inc_s;
                    end
                end else begin
                    small_d = small_q;
                end

                if ((state_q == ST_ALIVE) && frame_tick && hit) begin
                    // Losing the last life goes to DEAD; lives never go below 0.
                    if (big_up_s > 16'd1) begin
                        big_d   = big_up_s - 16'd1;
                        state_d = ST_INVULN;
                        cnt_d   = INVULN_FRAMES;
                    end else begin
                        big_d   = 16'd0;
                        state_d = ST_DEAD;
                        cnt_d   = 16'd0;
                    end
                end else begin
                    big_d = big_up_s;
                    if ((state_q == ST_INVULN) && frame_tick) begin
                        // Leave INVULN on the tick that takes the counter 1 -> 0.
                        if (cnt_q <= 16'd1) begin
                            cnt_d   = 16'd0;
                            state_d = ST_ALIVE;
                        end else begin
                            cnt_d   = cnt_q - 16'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end

            ST_DEAD: begin
                if (restart) begin
                    big_d   = START_BIG;
                    small_d = 16'd0;
                    cnt_d   = 16'd0;
                    state_d = ST_ALIVE;
                end else begin
                    big_d   = 16'd0;
                    small_d = small_q;
                end
            end

            default: begin
                // Unreachable encoding: recover to a safe, playable state.
                state_d = ST_ALIVE;
                cnt_d   = 16'd0;
            end
        endcase

        upd_d       = (small_d != small_q) || (big_d != big_q);
        invuln_d    = (state_d == ST_INVULN);
        game_over_d = (state_d == ST_DEAD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_ALIVE;
            small_q     <= 16'd0;
            big_q       <= START_BIG;
            cnt_q       <= 16'd0;
            upd_q       <= 1'b0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            small_q     <= small_d;
            big_q       <= big_d;
            cnt_q       <= cnt_d;
            upd_q       <= upd_d;
            invuln_q    <= invuln_d;
            game_over_q <= game_over_d;
        end
    end

    assign smallD    = small_q;
    assign bigD      = big_q;
    assign upd       = upd_q;
    assign invuln    = invuln_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_dk_stat_update.sv
// -----------------------------------------------------------------------------
// tb_dk_stat_update
//
// Self-checking bench for dk_stat_update. Every driven cycle pushes the
// expected outputs of a behavioural model into a scoreboard queue, which is
// popped and compared once the DUT has registered that cycle. Fixed
// checkpoints with literal expected values are compared on top of that.
// -----------------------------------------------------------------------------
module tb_dk_stat_update;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        hit = 1'b0;
    logic        collect = 1'b0;
    logic        restart = 1'b0;
    logic [15:0] smallD;
    logic [15:0] bigD;
    logic        upd;
    logic        invuln;
    logic        game_over;

    always #5 Clk = ~Clk;

    dk_stat_update dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .hit        (hit),
        .collect    (collect),
        .restart    (restart),
        .smallD     (smallD),
        .bigD       (bigD),
        .upd        (upd),
        .invuln     (invuln),
        .game_over  (game_over)
    );

    typedef struct packed {
        logic [15:0] sm;
        logic [15:0] bg;
        logic        u;
        logic        inv;
        logic        go;
    } out_t;

    typedef struct {
        logic rst;
        logic ft;
        logic h;
        logic c;
        logic rs;
        out_t exp;
    } vec_t;

    out_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model state: 0 alive, 1 invulnerable, 2 dead.
    int   m_state = 0;
    int   m_small = 0;
    int   m_big = 10;
    int   m_cnt = 0;
    logic m_upd = 1'b0;

    task automatic model(input logic r, input logic f, input logic h,
                         input logic c, input logic s);
        int ns, nb, os, ob;
        os = m_small;
        ob = m_big;
        if (r) begin
            m_state = 0; m_small = 0; m_big = 10; m_cnt = 0; m_upd = 1'b0;
        end else begin
            ns = m_small;
            nb = m_big;
            if (m_state == 2) begin
                if (s) begin ns = 0; nb = 10; m_state = 0; end
            end else begin
                if (c) begin
                    ns = ns + 1;
                    if (ns == 100) begin
                        ns = 0;
                        nb = (nb >= 99) ? 99 : nb + 1;
                    end
                end
                if (m_state == 0 && f && h) begin
                    nb = nb - 1;
                    if (nb == 0) m_state = 2;
                    else begin m_state = 1; m_cnt = 60; end
                end else if (m_state == 1 && f) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) m_state = 0;
                end
            end
            m_small = ns;
            m_big   = nb;
            m_upd   = (ns != os) || (nb != ob);
        end
    endtask

    function automatic out_t got_out();
        out_t g;
        g.sm = smallD; g.bg = bigD; g.u = upd; g.inv = invuln; g.go = game_over;
        return g;
    endfunction

    task automatic report(input string name, input out_t g, input out_t e);
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL %s: got small=%0d big=%0d upd=%b inv=%b go=%b, expected small=%0d big=%0d upd=%b inv=%b go=%b",
                     name, g.sm, g.bg, g.u, g.inv, g.go, e.sm, e.bg, e.u, e.inv, e.go);
        end
    endtask

    // One clock: drive, predict, wait for the registered result, compare.
    task automatic cyc(input logic r, input logic f, input logic h,
                       input logic c, input logic s);
        out_t e;
        Reset = r; frame_tick = f; hit = h; collect = c; restart = s;
        model(r, f, h, c, s);
        e.sm = 16'(m_small); e.bg = 16'(m_big); e.u = m_upd;
        e.inv = (m_state == 1); e.go = (m_state == 2);
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        e = sb_q.pop_front();
        report("scoreboard", got_out(), e);
        Reset = 1'b0; frame_tick = 1'b0; hit = 1'b0; collect = 1'b0; restart = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [15:0] sm, input logic [15:0] bg,
                             input logic u, input logic inv, input logic go);
        out_t e;
        e.sm = sm; e.bg = bg; e.u = u; e.inv = inv; e.go = go;
        report(name, got_out(), e);
    endtask

    // Take a hit, then sit out the full invulnerability window.
    task automatic lose_life();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (60) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t tbl[12];

    initial begin
        //            rst   ft    hit   col   rs      small   big     upd   inv   go
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '{16'd0, 16'd10, 1'b0, 1'b0, 1'b0}};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '{16'd1, 16'd10, 1'b1, 1'b0, 1'b0}};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '{16'd2, 16'd10, 1'b1, 1'b0, 1'b0}};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '{16'd2, 16'd10, 1'b0, 1'b0, 1'b0}};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '{16'd2, 16'd10, 1'b0, 1'b0, 1'b0}};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '{16'd2, 16'd10, 1'b0, 1'b0, 1'b0}};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '{16'd2, 16'd9,  1'b1, 1'b1, 1'b0}};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '{16'd2, 16'd9,  1'b0, 1'b1, 1'b0}};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '{16'd2, 16'd9,  1'b0, 1'b1, 1'b0}};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '{16'd3, 16'd9,  1'b1, 1'b1, 1'b0}};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '{16'd0, 16'd10, 1'b0, 1'b0, 1'b0}};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '{16'd0, 16'd10, 1'b0, 1'b0, 1'b0}};

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].rst, tbl[i].ft, tbl[i].h, tbl[i].c, tbl[i].rs);
            check_out($sformatf("table[%0d]", i), tbl[i].exp.sm, tbl[i].exp.bg,
                      tbl[i].exp.u, tbl[i].exp.inv, tbl[i].exp.go);
        end

        // 100 bananas give one life.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (99) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_out("collect99", 16'd99, 16'd10, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_out("oneup", 16'd0, 16'd11, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_out("oneup_upd_drop", 16'd0, 16'd11, 1'b0, 1'b0, 1'b0);

        // Invulnerability window with hit held.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_out("first_hit", 16'd0, 16'd9, 1'b1, 1'b1, 1'b0);
        repeat (59) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_out("invuln_59", 16'd0, 16'd9, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_out("invuln_end", 16'd0, 16'd9, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_out("second_hit", 16'd0, 16'd8, 1'b1, 1'b1, 1'b0);

        // Death, ignored inputs while dead, restart.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (9) lose_life();
        check_out("one_life", 16'd3, 16'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_out("death", 16'd3, 16'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_out("dead_collect", 16'd3, 16'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_out("dead_hit", 16'd3, 16'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_out("restart", 16'd0, 16'd10, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_out("restart_alive", 16'd0, 16'd10, 1'b0, 1'b0, 1'b0);

        // 1-up and hit in the same cycle cancel out.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) lose_life();
        repeat (99) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_out("pre_combo", 16'd99, 16'd5, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_out("combo", 16'd0, 16'd5, 1'b1, 1'b1, 1'b0);

        // Lives saturate at 99.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (8900) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_out("max_lives", 16'd0, 16'd99, 1'b1, 1'b0, 1'b0);
        repeat (99) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_out("saturate", 16'd0, 16'd99, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of INVULN.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (30) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_out("mid_invuln", 16'd0, 16'd9, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_out("reset_invuln", 16'd0, 16'd10, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_out("hit_after_reset", 16'd0, 16'd9, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
